// File: rtl/main_mem_ctrl.sv
// Main-memory backend for the cache mem_* port: one request at a time, fixed
// access latency, single-cycle registered ready pulse with read data or error.
module main_mem_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_adr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic                  mem_err_o,
    output logic                  busy_o,
    output logic [15:0]           rd_cnt_o,
    output logic [15:0]           wr_cnt_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [1:0]            state;
    logic [7:0]            lat_cnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]  written;

    logic                  in_range;
    logic                  commit;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           pattern;

    assign in_range = ({1'b0, adr_q} < (ADDR_WIDTH+1)'(MEM_DEPTH));
    assign idx      = adr_q[IDX_W-1:0];
    // The edge that moves WAIT to RESP lands exactly LATENCY edges after acceptance.
    assign commit   = (state == WAIT) && (lat_cnt == 8'(LATENCY - 1));
    assign pattern  = {16'hBEEF, 16'(adr_q)};
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            lat_cnt <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_valid_i) begin
                        we_q    <= mem_we_i;
                        adr_q   <= mem_adr_i;
                        wdata_q <= mem_wdata_i;
                        lat_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt + 8'd1;
                    if (commit) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Response, counters and written bits all update on the edge entering RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_ready_o <= 1'b0;
            mem_err_o   <= 1'b0;
            mem_rdata_o <= '0;
            rd_cnt_o    <= '0;
            wr_cnt_o    <= '0;
            written     <= '0;
        end else begin
            mem_ready_o <= commit;
            if (commit) begin
                mem_err_o <= !in_range;
                if (!in_range) begin
                    mem_rdata_o <= '0;
                end else if (we_q) begin
                    mem_rdata_o  <= wdata_q;
                    written[idx] <= 1'b1;
                    if (wr_cnt_o != 16'hFFFF) begin
                        wr_cnt_o <= wr_cnt_o + 16'd1;
                    end
                end else begin
                    mem_rdata_o <= written[idx] ? mem[idx] : DATA_WIDTH'(pattern);
                    if (rd_cnt_o != 16'hFFFF) begin
                        rd_cnt_o <= rd_cnt_o + 16'd1;
                    end
                end
            end
        end
    end

    // Array contents survive reset; only the written bits are cleared.
    always_ff @(posedge clk_i) begin
        if (rst_ni && commit && in_range && we_q) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Randomized self-checking bench for main_mem_ctrl against a transaction-level
// memory model (associative arrays, expected ready cycle = acceptance + LATENCY).
module tb_main_mem_ctrl;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, valid, we, ready, err, busy;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata, rdata;
    logic [15:0]   rd_cnt, wr_cnt;

    logic          rst1_n, valid1, we1, ready1, err1, busy1;
    logic [AW-1:0] adr1;
    logic [DW-1:0] wdata1, rdata1;
    logic [15:0]   rd_cnt1, wr_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [int];
    bit          model_written [int];
    int          model_rd;
    int          model_wr;

    main_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid), .mem_ready_o(ready),
        .mem_we_i(we), .mem_adr_i(adr), .mem_wdata_i(wdata), .mem_rdata_o(rdata),
        .mem_err_o(err), .busy_o(busy), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
    );

    main_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .LATENCY(1)) dut_lat1 (
        .clk_i(clk), .rst_ni(rst1_n), .mem_valid_i(valid1), .mem_ready_o(ready1),
        .mem_we_i(we1), .mem_adr_i(adr1), .mem_wdata_i(wdata1), .mem_rdata_o(rdata1),
        .mem_err_o(err1), .busy_o(busy1), .rd_cnt_o(rd_cnt1), .wr_cnt_o(wr_cnt1)
    );

    function automatic logic [31:0] exp_read(input int a);
        logic [31:0] av;
        av = a;
        if (model_written.exists(a)) return model_mem[a];
        return {16'hBEEF, av[15:0]};
    endfunction

    task automatic model_clear();
        model_written.delete();
        model_rd = 0;
        model_wr = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wait_idle: busy=%b required 0 within 50 cycles", busy);
        end
    endtask

    // One full transaction on the LATENCY=3 instance, with garbage inputs during WAIT.
    task automatic do_req(input bit w, input logic [15:0] a, input logic [31:0] d, input string tag);
        logic [31:0] exp_d;
        logic        exp_e;
        wait_idle();
        valid = 1'b1; we = w; adr = a; wdata = d;
        if (int'(a) < DEPTH) begin
            exp_e = 1'b0;
            if (w) begin
                exp_d = d;
                model_mem[int'(a)] = d;
                model_written[int'(a)] = 1'b1;
                model_wr++;
            end else begin
                exp_d = exp_read(int'(a));
                model_rd++;
            end
        end else begin
            exp_e = 1'b1;
            exp_d = '0;
        end
        @(posedge clk);
        for (int k = 0; k <= LAT + 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== (k == LAT)) begin
                n_fail++;
                $display("[TB] FAIL %s ready cycle %0d: got %b required %b", tag, k, ready, (k == LAT));
            end
            n_checks++;
            if (busy !== (k <= LAT + 1)) begin
                n_fail++;
                $display("[TB] FAIL %s busy cycle %0d: got %b required %b", tag, k, busy, (k <= LAT + 1));
            end
            if (k >= LAT) begin
                n_checks++;
                if (rdata !== exp_d || err !== exp_e) begin
                    n_fail++;
                    $display("[TB] FAIL %s rdata/err cycle %0d: got %h/%b required %h/%b",
                             tag, k, rdata, err, exp_d, exp_e);
                end
            end
            if (k == LAT) begin
                n_checks++;
                if (rd_cnt !== 16'(model_rd) || wr_cnt !== 16'(model_wr)) begin
                    n_fail++;
                    $display("[TB] FAIL %s counters: got rd=%0d wr=%0d required rd=%0d wr=%0d",
                             tag, rd_cnt, wr_cnt, model_rd, model_wr);
                end
            end
            if (k < LAT + 1) begin
                valid = 1'($urandom); we = 1'($urandom); adr = 16'($urandom); wdata = $urandom;
            end else begin
                valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst1_n = 1'b0;
        valid = 1'b0; we = 1'b0; adr = '0; wdata = '0;
        valid1 = 1'b0; we1 = 1'b0; adr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ready, err, busy, rdata, rd_cnt, wr_cnt} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got ready=%b err=%b busy=%b rdata=%h rd=%h wr=%h required all 0",
                     ready, err, busy, rdata, rd_cnt, wr_cnt);
        end
        n_checks++;
        if ({ready1, err1, busy1, rdata1, rd_cnt1, wr_cnt1} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state_lat1: got ready=%b busy=%b rdata=%h required all 0",
                     ready1, busy1, rdata1);
        end
        rst_n = 1'b1; rst1_n = 1'b1;
        model_clear();
    endtask

    task automatic test_read_pattern();
        do_req(1'b0, 16'h0020, 32'h0, "read_pattern_0020");
    endtask

    task automatic test_write_read();
        do_req(1'b1, 16'h0010, 32'hDEADBEEF, "write_0010");
        do_req(1'b0, 16'h0010, 32'h0, "read_back_0010");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        int          rd0;
        wait_idle();
        exp_d = exp_read(5);
        rd0 = model_rd;
        valid = 1'b1; we = 1'b0; adr = 16'h0005; wdata = '0;
        @(posedge clk);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== (k == 3 || k == 9)) begin
                n_fail++;
                $display("[TB] FAIL held_valid ready cycle %0d: got %b required %b", k, ready, (k == 3 || k == 9));
            end
            n_checks++;
            if (busy !== (k != 5 && k != 11)) begin
                n_fail++;
                $display("[TB] FAIL held_valid busy cycle %0d: got %b required %b", k, busy, (k != 5 && k != 11));
            end
            if (k == 3 || k == 9) begin
                n_checks++;
                if (rdata !== exp_d || rd_cnt !== 16'(rd0 + (k == 3 ? 1 : 2))) begin
                    n_fail++;
                    $display("[TB] FAIL held_valid data cycle %0d: got %h rd=%0d required %h rd=%0d",
                             k, rdata, rd_cnt, exp_d, rd0 + (k == 3 ? 1 : 2));
                end
            end
        end
        valid = 1'b0;
        model_rd = rd0 + 2;
    endtask

    task automatic test_out_of_range();
        do_req(1'b1, 16'h0400, 32'h12345678, "oor_write_0400");
        do_req(1'b0, 16'h0400, 32'h0, "oor_read_0400");
        do_req(1'b0, 16'h0000, 32'h0, "read_pattern_0000");
    endtask

    task automatic test_reset_mid_wait();
        do_req(1'b1, 16'h0030, 32'hCAFEF00D, "write_0030");
        wait_idle();
        valid = 1'b1; we = 1'b1; adr = 16'h0031; wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int k = 0; k <= LAT + 3; k++) begin
            n_checks++;
            if (ready !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_wait cycle %0d: got ready=%b busy=%b required 0/0", k, ready, busy);
            end
            @(negedge clk);
        end
        n_checks++;
        if (rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_wait counters: got rd=%0d wr=%0d required 0/0", rd_cnt, wr_cnt);
        end
        do_req(1'b0, 16'h0030, 32'h0, "read_after_reset_0030");
        do_req(1'b0, 16'h0031, 32'h0, "read_after_reset_0031");
    endtask

    task automatic test_latency1();
        logic [31:0] d2;
        logic [31:0] exp_d [3];
        logic        w_list [3];
        logic [15:0] a_list [3];
        d2 = $urandom;
        w_list = '{1'b0, 1'b1, 1'b0};
        a_list = '{16'h0001, 16'h0002, 16'h0002};
        exp_d  = '{32'hBEEF0001, d2, d2};
        for (int t = 0; t < 3; t++) begin
            valid1 = 1'b1; we1 = w_list[t]; adr1 = a_list[t]; wdata1 = d2;
            @(posedge clk);
            for (int k = 0; k <= 3; k++) begin
                @(negedge clk);
                valid1 = 1'b0;
                n_checks++;
                if (ready1 !== (k == 1)) begin
                    n_fail++;
                    $display("[TB] FAIL lat1 req%0d ready cycle %0d: got %b required %b", t, k, ready1, (k == 1));
                end
                if (k == 1) begin
                    n_checks++;
                    if (rdata1 !== exp_d[t] || err1 !== 1'b0) begin
                        n_fail++;
                        $display("[TB] FAIL lat1 req%0d data: got %h/%b required %h/0", t, rdata1, err1, exp_d[t]);
                    end
                end
            end
        end
        n_checks++;
        if (rd_cnt1 !== 16'd2 || wr_cnt1 !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL lat1 counters: got rd=%0d wr=%0d required 2/1", rd_cnt1, wr_cnt1);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 1279));
            else                           a = 16'($urandom_range(0, 15));
            do_req(1'($urandom), a, $urandom, "random");
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_read_pattern();
        test_write_read();
        test_back_to_back();
        test_reset();
        test_out_of_range();
        test_reset_mid_wait();
        test_latency1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
Main-memory backend that sits directly downstream of cache_wrapper and serves its mem_* request port.
- Accepts one request at a time, waits a fixed access latency, then completes the access against an internal word array.
- Signals completion with a single-cycle ready pulse carrying read data or an error flag.
- Replaces the behavioural memory model in cache-level benches and is synthesizable for SoC integration.

Parameters:
ADDR_WIDTH, 16, width of word address from cache.
DATA_WIDTH, 32, data word width.
MEM_DEPTH, 1024, number of words in array; power of two, <= 2**ADDR_WIDTH.
LATENCY, 3, cycles from request acceptance to ready pulse; legal range 1..255.

Ports:
clk_i  in  1  clock, all logic on rising edge.
rst_ni  in  1  synchronous active-low reset.
mem_valid_i  in  1  request valid from cache (cache mem_valid_o).
mem_ready_o  out  1  one-cycle completion pulse (cache mem_ready_i).
mem_we_i  in  1  1 = write, 0 = read.
mem_adr_i  in  ADDR_WIDTH  word address.
mem_wdata_i  in  DATA_WIDTH  write data.
mem_rdata_o  out  DATA_WIDTH  read data, valid when mem_ready_o=1.
mem_err_o  out  1  out-of-range flag, valid when mem_ready_o=1.
busy_o  out  1  high in any state other than IDLE.
rd_cnt_o  out  16  completed good reads, saturating.
wr_cnt_o  out  16  completed good writes, saturating.

Behaviour:
- Reset (rst_ni=0 at a rising edge):
  - State goes to IDLE; mem_ready_o=0, mem_err_o=0, mem_rdata_o=0, busy_o=0.
  - rd_cnt_o=0, wr_cnt_o=0; all per-word written bits cleared.
  - Array data is not reset.
- FSM states: IDLE, WAIT, RESP, DONE.
- IDLE: at an edge with mem_valid_i=1, latch we/adr/wdata, load latency counter=0, go to WAIT. Otherwise stay.
- WAIT:
  - Counter increments each cycle.
  - Moves to RESP at the edge that makes the request's acceptance edge T0 plus LATENCY, so mem_ready_o is high during cycle [T0+LATENCY, T0+LATENCY+1).
  - Inputs are ignored while in WAIT; only latched values are used.
- RESP: mem_ready_o=1 for exactly one cycle, registered, with no combinational path from inputs. Transition to DONE.
- DONE:
  - One cycle with mem_valid_i ignored. This absorbs the cache's registered valid deassert and prevents a held valid from re-triggering the same request.
  - Then go to IDLE.
  - Minimum request spacing is LATENCY+3 cycles (edge T0 to next acceptance edge).
- In range: latched adr < MEM_DEPTH.
  - Read: mem_rdata_o = array word if its written bit is set, else {16'hBEEF, adr[15:0]} zero-extended or truncated to DATA_WIDTH.
  - Write: array word and its written bit update at the edge entering RESP. mem_rdata_o = wdata echoed.
  - mem_err_o=0.
- Out of range: mem_err_o=1 with ready. Write is dropped, mem_rdata_o=0, counters not incremented.
- Counters increment by 1 at the edge entering RESP for good reads/writes. Each holds at 16'hFFFF on overflow.
- mem_rdata_o and mem_err_o hold their last value after RESP until the next RESP.
- Reset in WAIT/RESP/DONE: the pending request is discarded and no ready is emitted. A write not yet committed is lost.
- A read of a word written before reset returns the pattern, because its written bit is cleared.

Test Plan:
1. LATENCY=3; read 0x0020 accepted at edge T0 -> mem_ready_o=1 only in cycle T0+3; rdata=0xBEEF0020, err=0; rd_cnt_o=1; busy_o high from T0+1 to T0+5.
2. Write 0x0010 data 0xDEADBEEF, then read 0x0010 -> read returns 0xDEADBEEF; wr_cnt_o=1, rd_cnt_o=1.
3. Hold mem_valid_i=1 continuously with read 0x0005 -> ready pulses at T0+3 and T0+9 only (acceptances at T0 and T0+6); rd_cnt_o=2.
4. MEM_DEPTH=1024; write 0x0400 data 0x12345678 then read 0x0400 -> both respond with err=1, read rdata=0; counters stay 0; read 0x0000 returns 0xBEEF0000.
5. Write 0x0030 data 0xCAFEF00D completes; next write accepted, rst_ni=0 for one cycle during WAIT -> no ready pulse; counters 0; read 0x0030 returns 0xBEEF0030.
6. LATENCY=1 build; read 0x0001 accepted at T0 -> ready in cycle T0+1, rdata=0xBEEF0001.
